// File: rtl/oldland_defines.sv
// Shared encodings for the Oldland pipeline sequencing controller.
package oldland_defines;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    HAZARD     = 3'd1,
    FLUSH      = 3'd2,
    EXC_DRAIN  = 3'd3,
    CACHE_WAIT = 3'd4
  } pipe_state_e;

  localparam int FLUSH_CYCLES_DEF = 2;

endpackage

// File: rtl/oldland_hazard_detect.sv
// Load-use hazard compare between decode sources and the execute-stage load destination.
module oldland_hazard_detect (
  input  logic       dec_valid,
  input  logic [3:0] dec_ra_sel,
  input  logic [3:0] dec_rb_sel,
  input  logic       dec_uses_ra,
  input  logic       dec_uses_rb,
  input  logic       ex_valid,
  input  logic [3:0] ex_rd_sel,
  input  logic       ex_update_rd,
  input  logic       ex_mem_load,
  output logic       hazard
);

  logic ra_hit;
  logic rb_hit;

  assign ra_hit = dec_uses_ra && (ex_rd_sel == dec_ra_sel);
  assign rb_hit = dec_uses_rb && (ex_rd_sel == dec_rb_sel);
  assign hazard = ex_valid && ex_mem_load && ex_update_rd && dec_valid && (ra_hit || rb_hit);

endmodule

// File: rtl/oldland_pipe_ctl.sv
// Oldland front-end sequencer: load-use bubbles, redirect flushes, exception entry,
// cache-op waits and data-bus back-pressure.
//   state      | meaning
//   RUN        | normal issue, watching for redirects/exceptions/cache ops/hazards
//   HAZARD     | one idle cycle while the load leaves execute
//   FLUSH      | fetch/decode killed after a redirect, counting down
//   EXC_DRAIN  | exception pending, waiting for the data bus to go idle
//   CACHE_WAIT | cache op in execute, waiting for cache_done
module oldland_pipe_ctl
  import oldland_defines::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic [3:0] dec_ra_sel,
  input  logic [3:0] dec_rb_sel,
  input  logic       dec_uses_ra,
  input  logic       dec_uses_rb,
  input  logic       dec_exception,
  input  logic       ex_valid,
  input  logic [3:0] ex_rd_sel,
  input  logic       ex_update_rd,
  input  logic       ex_mem_load,
  input  logic       ex_cache_instr,
  input  logic       cache_done,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       bubble_ex,
  output logic       kill_fd,
  output logic       exc_enter,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic             FLUSH_ONE  = (FLUSH_CYCLES == 1);

  pipe_state_e      st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             frozen;
  logic             stall_c, bubble_c, kill_c, exc_c;

  oldland_hazard_detect u_hazard (
    .dec_valid    (dec_valid),
    .dec_ra_sel   (dec_ra_sel),
    .dec_rb_sel   (dec_rb_sel),
    .dec_uses_ra  (dec_uses_ra),
    .dec_uses_rb  (dec_uses_rb),
    .ex_valid     (ex_valid),
    .ex_rd_sel    (ex_rd_sel),
    .ex_update_rd (ex_update_rd),
    .ex_mem_load  (ex_mem_load),
    .hazard       (hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= RUN;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign frozen = mem_busy && (st_q != EXC_DRAIN);

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    kill_c   = 1'b0;
    exc_c    = 1'b0;
    if (frozen) begin
      stall_c = 1'b1;
    end else begin
      case (st_q)
        // A taken branch outranks an exception: the excepting instruction is on the wrong path.
        RUN: begin
          if (branch_taken) begin
            kill_c = 1'b1;
            cnt_d  = FLUSH_LOAD;
            st_d   = FLUSH_ONE ? RUN : FLUSH;
          end else if (dec_exception && dec_valid) begin
            stall_c = 1'b1;
            st_d    = EXC_DRAIN;
          end else if (ex_valid && ex_cache_instr) begin
            stall_c = 1'b1;
            st_d    = CACHE_WAIT;
          end else if (hazard) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            st_d     = HAZARD;
          end
        end
        HAZARD: begin
          if (branch_taken) begin
            kill_c = 1'b1;
            cnt_d  = FLUSH_LOAD;
            st_d   = FLUSH_ONE ? RUN : FLUSH;
          end else begin
            st_d = RUN;
          end
        end
        FLUSH: begin
          kill_c = 1'b1;
          if (branch_taken) begin
            cnt_d = FLUSH_LOAD;
            st_d  = FLUSH_ONE ? RUN : FLUSH;
          end else if (cnt_q <= CNT_W'(1)) begin
            cnt_d = '0;
            st_d  = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        EXC_DRAIN: begin
          if (mem_busy) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
          end else begin
            exc_c  = 1'b1;
            kill_c = 1'b1;
            cnt_d  = FLUSH_LOAD;
            st_d   = FLUSH_ONE ? RUN : FLUSH;
          end
        end
        CACHE_WAIT: begin
          if (cache_done) begin
            st_d = RUN;
          end else begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
          end
        end
        default: st_d = RUN;
      endcase
    end
  end

  assign stall_fetch  = stall_c && !rst;
  assign stall_decode = stall_c && !rst;
  assign bubble_ex    = bubble_c && !rst;
  assign kill_fd      = kill_c && !rst;
  assign exc_enter    = exc_c && !rst;
  assign state        = st_q;

endmodule

// File: tb/tb_oldland_pipe_ctl.sv
// Directed bench for oldland_pipe_ctl; a second instance runs with a one-cycle flush.
module tb_oldland_pipe_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_uses_ra, dec_uses_rb, dec_exception;
  logic [3:0] dec_ra_sel, dec_rb_sel, ex_rd_sel;
  logic       ex_valid, ex_update_rd, ex_mem_load, ex_cache_instr;
  logic       cache_done, branch_taken, mem_busy;

  logic       stall_fetch, stall_decode, bubble_ex, kill_fd, exc_enter;
  logic [2:0] state;
  logic       stall_fetch1, stall_decode1, bubble_ex1, kill_fd1, exc_enter1;
  logic [2:0] state1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oldland_pipe_ctl #(.FLUSH_CYCLES(2), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ra_sel(dec_ra_sel),
    .dec_rb_sel(dec_rb_sel), .dec_uses_ra(dec_uses_ra), .dec_uses_rb(dec_uses_rb),
    .dec_exception(dec_exception), .ex_valid(ex_valid), .ex_rd_sel(ex_rd_sel),
    .ex_update_rd(ex_update_rd), .ex_mem_load(ex_mem_load),
    .ex_cache_instr(ex_cache_instr), .cache_done(cache_done),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .bubble_ex(bubble_ex),
    .kill_fd(kill_fd), .exc_enter(exc_enter), .state(state)
  );

  oldland_pipe_ctl #(.FLUSH_CYCLES(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ra_sel(dec_ra_sel),
    .dec_rb_sel(dec_rb_sel), .dec_uses_ra(dec_uses_ra), .dec_uses_rb(dec_uses_rb),
    .dec_exception(dec_exception), .ex_valid(ex_valid), .ex_rd_sel(ex_rd_sel),
    .ex_update_rd(ex_update_rd), .ex_mem_load(ex_mem_load),
    .ex_cache_instr(ex_cache_instr), .cache_done(cache_done),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .stall_fetch(stall_fetch1), .stall_decode(stall_decode1), .bubble_ex(bubble_ex1),
    .kill_fd(kill_fd1), .exc_enter(exc_enter1), .state(state1)
  );

  // Packed view: {state, stall_fetch, stall_decode, bubble_ex, kill_fd, exc_enter}
  task automatic chk(input string tag, input logic [2:0] st, input logic sf, input logic sd,
                     input logic bx, input logic kf, input logic ee);
    logic [7:0] obs, exp;
    obs = {state, stall_fetch, stall_decode, bubble_ex, kill_fd, exc_enter};
    exp = {st, sf, sd, bx, kf, ee};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed st=%0d sf/sd/bx/kf/ee=%b required st=%0d sf/sd/bx/kf/ee=%b",
             tag, obs[7:5], obs[4:0], exp[7:5], exp[4:0]);
    end
  endtask

  task automatic chk1(input string tag, input logic [2:0] st, input logic kf);
    logic [3:0] obs, exp;
    obs = {state1, kill_fd1};
    exp = {st, kf};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed st=%0d kill=%b required st=%0d kill=%b",
             tag, obs[3:1], obs[0], exp[3:1], exp[0]);
    end
  endtask

  task automatic idle();
    rst = 0; dec_valid = 0; dec_uses_ra = 0; dec_uses_rb = 0; dec_exception = 0;
    dec_ra_sel = 0; dec_rb_sel = 0; ex_rd_sel = 0; ex_valid = 0; ex_update_rd = 0;
    ex_mem_load = 0; ex_cache_instr = 0; cache_done = 0; branch_taken = 0; mem_busy = 0;
  endtask

  // Inputs are applied on the falling edge and checked 1ns later, mid-cycle.
  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic load_use_ra();
    ex_valid = 1; ex_mem_load = 1; ex_update_rd = 1; ex_rd_sel = 4'd3;
    dec_valid = 1; dec_uses_ra = 1; dec_ra_sel = 4'd3; dec_rb_sel = 4'd7;
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk); rst = 1; #1;
    chk("rst_outputs_low", 3'bxxx === 3'bxxx ? state : 3'd0, 0, 0, 0, 0, 0);
    cyc(); rst = 1; load_use_ra(); branch_taken = 1; #1;
    chk("reset_state", 0, 0, 0, 0, 0, 0);

    // load-use on ra
    cyc(); load_use_ra(); #1;            chk("lu_ra_stall", 0, 1, 1, 1, 0, 0);
    cyc(); #1;                           chk("lu_hazard_state", 1, 0, 0, 0, 0, 0);
    cyc(); #1;                           chk("lu_back_run", 0, 0, 0, 0, 0, 0);
    cyc(); load_use_ra(); dec_uses_ra = 0; #1;
                                         chk("lu_no_use_ra", 0, 0, 0, 0, 0, 0);
    cyc(); load_use_ra(); ex_update_rd = 0; #1;
                                         chk("lu_no_update", 0, 0, 0, 0, 0, 0);
    cyc(); load_use_ra(); ex_mem_load = 0; #1;
                                         chk("lu_not_load", 0, 0, 0, 0, 0, 0);
    cyc(); load_use_ra(); dec_uses_ra = 0; dec_uses_rb = 1; dec_rb_sel = 4'd3; #1;
                                         chk("lu_rb_stall", 0, 1, 1, 1, 0, 0);
    cyc(); #1;                           chk("lu_rb_hazard", 1, 0, 0, 0, 0, 0);

    // branch redirect
    cyc(); branch_taken = 1; #1;
    chk("br_kill0", 0, 0, 0, 0, 1, 0);   chk1("br1_kill0", 0, 1);
    cyc(); #1;
    chk("br_kill1", 2, 0, 0, 0, 1, 0);   chk1("br1_done", 0, 0);
    cyc(); #1;                           chk("br_done", 0, 0, 0, 0, 0, 0);

    // exception under memory traffic
    cyc(); dec_valid = 1; dec_exception = 1; #1;
                                         chk("exc_entry", 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_busy = 1; #1;           chk("exc_drain_busy", 3, 1, 1, 1, 0, 0);
    end
    cyc(); #1;                           chk("exc_enter", 3, 0, 0, 0, 1, 1);
    cyc(); #1;                           chk("exc_flush", 2, 0, 0, 0, 1, 0);
    cyc(); #1;                           chk("exc_done", 0, 0, 0, 0, 0, 0);

    // cache op
    cyc(); ex_valid = 1; ex_cache_instr = 1; #1;
                                         chk("cache_entry", 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;                         chk("cache_wait", 4, 1, 1, 1, 0, 0);
    end
    cyc(); cache_done = 1; #1;           chk("cache_done", 4, 0, 0, 0, 0, 0);
    cyc(); #1;                           chk("cache_run", 0, 0, 0, 0, 0, 0);

    // branch beats exception, then freeze during FLUSH
    cyc(); branch_taken = 1; dec_valid = 1; dec_exception = 1; #1;
                                         chk("br_exc_same", 0, 0, 0, 0, 1, 0);
    cyc(); mem_busy = 1; dec_valid = 1; dec_exception = 1; #1;
                                         chk("flush_frozen0", 2, 1, 1, 0, 0, 0);
    cyc(); mem_busy = 1; #1;             chk("flush_frozen1", 2, 1, 1, 0, 0, 0);
    cyc(); dec_valid = 1; dec_exception = 1; #1;
                                         chk("flush_resume", 2, 0, 0, 0, 1, 0);
    cyc(); #1;                           chk("flush_exit", 0, 0, 0, 0, 0, 0);

    // branch reload during FLUSH
    cyc(); branch_taken = 1; #1;         chk("reload_br0", 0, 0, 0, 0, 1, 0);
    cyc(); branch_taken = 1; #1;         chk("reload_br1", 2, 0, 0, 0, 1, 0);
    cyc(); #1;                           chk("reload_tail", 2, 0, 0, 0, 1, 0);
    cyc(); #1;                           chk("reload_exit", 0, 0, 0, 0, 0, 0);

    // freeze in RUN masks hazard
    cyc(); load_use_ra(); mem_busy = 1; #1;
                                         chk("run_frozen", 0, 1, 1, 0, 0, 0);
    cyc(); #1;                           chk("run_frozen_hold", 0, 0, 0, 0, 0, 0);

    // reset inside EXC_DRAIN
    cyc(); dec_valid = 1; dec_exception = 1; #1;
                                         chk("rst_exc_entry", 0, 1, 1, 0, 0, 0);
    cyc(); mem_busy = 1; #1;             chk("rst_exc_drain", 3, 1, 1, 1, 0, 0);
    cyc(); rst = 1; mem_busy = 1; #1;    chk("rst_exc_forced", 3, 0, 0, 0, 0, 0);
    cyc(); #1;                           chk("rst_exc_run", 0, 0, 0, 0, 0, 0);

    // reset inside FLUSH
    cyc(); branch_taken = 1; #1;         chk("rst_fl_br", 0, 0, 0, 0, 1, 0);
    cyc(); rst = 1; #1;                  chk("rst_fl_forced", 2, 0, 0, 0, 0, 0);
    cyc(); #1;                           chk("rst_fl_run", 0, 0, 0, 0, 0, 0);

    // hazard after reset
    cyc(); load_use_ra(); #1;            chk("post_rst_lu", 0, 1, 1, 1, 0, 0);
    cyc(); #1;                           chk("post_rst_haz", 1, 0, 0, 0, 0, 0);
    cyc(); #1;                           chk("post_rst_run", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
